counter_core: RTL and testbench
===============================

Name: counter_core

Overview:
- Control stage directly upstream of the seven-segment display driver.
- Produces the two binary values that block renders:
  - counter_settings: a 5-bit step size chosen by the user.
  - memory: a 7-bit running accumulator that advances by the step once per tick.
- Debounces three push buttons and sequences SET/RUN/PAUSE with a small FSM.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized cycles required before a button level change is accepted.
- TICK_DIV, 50000000: clock cycles per accumulate tick in RUN (1 Hz at 50 MHz).
- MEM_MOD, 100: modulus of memory; legal range 32..128.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- key_start_n  input  1  raw button, active-low, asynchronous to clock; toggles run/pause, or starts from SET
- key_inc_n  input  1  raw button, active-low; increments step in SET
- key_clr_n  input  1  raw button, active-low; clears memory and returns to SET
- counter_settings  output  5  current step size, 1..31
- memory  output  7  accumulator value, 0..MEM_MOD-1
- run_led  output  1  high while state is RUN
- tick_led  output  1  one-cycle pulse on each accumulate

Behaviour:

Clocking and reset:
- One clock domain.
- Reset is asynchronous and active-high.
- Reset values:
  - state = SET
  - counter_settings = 1
  - memory = 0
  - run_led = 0
  - tick_led = 0
  - prescaler = 0
  - synchronizers and debounced levels = released (1)
  - debounce counters = 0

Button path (per button, identical):
- 2-flop synchronizer.
- Debounce counter:
  - increments while the synchronized level differs from the debounced level;
  - clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press pulse: one cycle, asserted when the debounced level goes 1->0.
- Release produces no pulse.
- Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Latency: a clean raw press affects registered outputs exactly DEBOUNCE_CYCLES+3 clocks after the raw falling edge.
  - 2 cycles sync
  - DEBOUNCE_CYCLES cycles count
  - 1 cycle output register

FSM (states SET, RUN, PAUSE):
- SET:
  - inc pulse: counter_settings += 1, wrapping 31 -> 1 (never 0).
  - start pulse: go to RUN.
- RUN:
  - start pulse: go to PAUSE.
  - inc ignored.
- PAUSE:
  - start pulse: go to RUN.
  - inc ignored.
- Any state, clr pulse: go to SET, memory = 0; counter_settings unchanged.
- Priority when pulses coincide: clr > start > inc.

Prescaler:
- Counts 0..TICK_DIV-1 only in RUN.
- Cleared on every entry to RUN; holds its value in SET and PAUSE.
- tick fires on the cycle the count equals TICK_DIV-1; count then wraps to 0.
- The first tick after entering RUN occurs TICK_DIV cycles after entry.

Accumulate:
- On tick with state remaining RUN (no start or clr pulse in the same cycle):
  - sum = memory + counter_settings, computed 8 bits wide;
  - memory = sum - MEM_MOD if sum >= MEM_MOD, else sum.
- tick_led pulses in that same update cycle.
- A tick coinciding with a start or clr pulse is discarded:
  - no memory change;
  - no tick_led pulse.

Output registers:
- All outputs are registered.
- run_led = (state == RUN), registered.
- memory is always < MEM_MOD; counter_settings is always in 1..31.

Reset mid-operation:
- Immediate return to reset values, including any debounce in progress.
- A button held through reset release is accepted as a new press after the debounce window.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=5, MEM_MOD=100):
1. Reset asserted mid-RUN with memory=37 -> outputs asynchronously go to counter_settings=1, memory=0, run_led=0; after release, state is SET.
2. In SET, three clean inc presses -> counter_settings=4; then a 3-cycle glitch on key_inc_n -> counter_settings stays 4; each accepted press lands exactly 7 clocks after its raw edge.
3. Thirty-one inc presses from 1 -> counter_settings wraps 31 -> 1; inc presses in RUN or PAUSE -> no change.
4. step=7, start pressed, run 15 ticks -> memory sequence 7, 14, ..., 98, then 5 (105-100); tick_led pulses exactly every 5 cycles; first tick 5 cycles after RUN entry.
5. Start pulse on the same cycle as a tick -> state PAUSE, memory unchanged, no tick_led. Second start -> RUN; the next tick arrives 5 cycles later.
6. clr and start pressed simultaneously in RUN with memory=42, step=9 -> state SET, memory=0, counter_settings=9, run_led=0.

Source files
------------

// File: rtl/counter_core.sv
// counter_core: control stage feeding the seven-segment display driver.
// Three push buttons are synchronized and debounced. A SET/RUN/PAUSE FSM
// sequences them. In RUN the memory accumulator advances by counter_settings
// once per prescaler tick, modulo MEM_MOD.

// Per-button synchronizer + debouncer producing a one-cycle press pulse.
module counter_core_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  logic [CW-1:0] cnt_nxt_s;
  logic          level_nxt_s;
  logic          press_nxt_s;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce decision: count differing cycles, flip the level on the last one.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    press_nxt_s = 1'b0;
    if (sync2_r == level_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r >= CNT_LAST) begin
      // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
      cnt_nxt_s   = CNT_ZERO;
      level_nxt_s = sync2_r;
      // Only the 1->0 transition is a press; release is silent.
      press_nxt_s = ~sync2_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce counter, accepted level and registered press pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b1;
      press_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      press_r <= press_nxt_s;
    end
  end

  assign press = press_r;

endmodule

// Top-level control stage.
module counter_core #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_DIV        = 50000000,
  parameter int MEM_MOD         = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_inc_n,
  input  logic       key_clr_n,
  output logic [4:0] counter_settings,
  output logic [6:0] memory,
  output logic       run_led,
  output logic       tick_led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    MOD_W      = 8'(MEM_MOD);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state_r;
  logic [4:0]    settings_r;
  logic [6:0]    memory_r;
  logic          run_led_r;
  logic          tick_led_r;
  logic [PW-1:0] presc_r;

  state_t        state_nxt_s;
  logic [4:0]    settings_nxt_s;
  logic [6:0]    memory_nxt_s;
  logic          run_led_nxt_s;
  logic          tick_led_nxt_s;
  logic [PW-1:0] presc_nxt_s;

  logic          start_press_s;
  logic          inc_press_s;
  logic          clr_press_s;
  logic          tick_s;
  logic [7:0]    sum_s;
  logic [6:0]    mem_wrapped_s;
  logic [4:0]    settings_inc_s;

  counter_core_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clock (clock),
    .reset (reset),
    .key_n (key_start_n),
    .press (start_press_s)
  );

  counter_core_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clock (clock),
    .reset (reset),
    .key_n (key_inc_n),
    .press (inc_press_s)
  );

  counter_core_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clock (clock),
    .reset (reset),
    .key_n (key_clr_n),
    .press (clr_press_s)
  );

  // Tick is only meaningful while running; the count is frozen elsewhere.
  assign tick_s = (state_r == ST_RUN) && (presc_r == PRESC_LAST);

  // Sum kept 8 bits wide so memory + step never overflows before the modulo.
  assign sum_s         = {1'b0, memory_r} + {3'b000, settings_r};
  assign mem_wrapped_s = (sum_s >= MOD_W) ? 7'(sum_s - MOD_W) : sum_s[6:0];

  // Step wraps 31 -> 1 so it can never become zero.
  assign settings_inc_s = (settings_r >= 5'd31 || settings_r == 5'd0) ? 5'd1
                                                                      : settings_r + 5'd1;

  // Next-state, accumulator and prescaler logic; priority clr > start > inc.
  always_comb begin
    state_nxt_s    = state_r;
    settings_nxt_s = settings_r;
    memory_nxt_s   = memory_r;
    tick_led_nxt_s = 1'b0;
    presc_nxt_s    = presc_r;

    if (clr_press_s) begin
      state_nxt_s  = ST_SET;
      memory_nxt_s = 7'd0;
    end else begin
      case (state_r)
        ST_SET: begin
          if (start_press_s) begin
            state_nxt_s = ST_RUN;
          end else if (inc_press_s) begin
            settings_nxt_s = settings_inc_s;
          end else begin
            settings_nxt_s = settings_r;
          end
        end
        ST_RUN: begin
          if (start_press_s) begin
            // A tick landing with the start pulse is discarded.
            state_nxt_s = ST_PAUSE;
          end else if (tick_s) begin
            memory_nxt_s   = mem_wrapped_s;
            tick_led_nxt_s = 1'b1;
          end else begin
            memory_nxt_s = memory_r;
          end
        end
        ST_PAUSE: begin
          if (start_press_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        default: begin
          state_nxt_s = ST_SET;
        end
      endcase
    end

    // Restart the tick period on every entry to RUN so the first tick is a full period away.
    if ((state_r != ST_RUN) && (state_nxt_s == ST_RUN)) begin
      presc_nxt_s = PRESC_ZERO;
    end else if (state_r == ST_RUN) begin
      if (tick_s) begin
        presc_nxt_s = PRESC_ZERO;
      end else begin
        presc_nxt_s = presc_r + PRESC_ONE;
      end
    end else begin
      presc_nxt_s = presc_r;
    end

    run_led_nxt_s = (state_nxt_s == ST_RUN);
  end

  // State, prescaler and all output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_SET;
      settings_r <= 5'd1;
      memory_r   <= 7'd0;
      run_led_r  <= 1'b0;
      tick_led_r <= 1'b0;
      presc_r    <= PRESC_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      settings_r <= settings_nxt_s;
      memory_r   <= memory_nxt_s;
      run_led_r  <= run_led_nxt_s;
      tick_led_r <= tick_led_nxt_s;
      presc_r    <= presc_nxt_s;
    end
  end

  assign counter_settings = settings_r;
  assign memory           = memory_r;
  assign run_led          = run_led_r;
  assign tick_led         = tick_led_r;

endmodule

// File: tb/tb_counter_core.sv
// Testbench for counter_core with DEBOUNCE_CYCLES=4, TICK_DIV=5, MEM_MOD=100.
`timescale 1ns/1ps
module tb_counter_core;

  localparam int DEB  = 4;
  localparam int TDIV = 5;
  localparam int MOD  = 100;
  localparam int NV   = 36;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic [4:0] counter_settings;
  logic [6:0] memory;
  logic       run_led;
  logic       tick_led;

  counter_core #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV       (TDIV),
    .MEM_MOD        (MOD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .key_start_n      (key_start_n),
    .key_inc_n        (key_inc_n),
    .key_clr_n        (key_clr_n),
    .counter_settings (counter_settings),
    .memory           (memory),
    .run_led          (run_led),
    .tick_led         (tick_led)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  int cyc = 0;
  // Posedge counter used to timestamp expectations.
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int model_mem = 0;

  typedef struct {
    int cyc;
    int mem;
  } tick_t;
  tick_t sb_q[$];
  tick_t mon_e;

  typedef struct {
    logic s;
    logic i;
    logic c;
    int   es;
    int   em;
    int   er;
  } vec_t;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic s, input logic i, input logic c,
                              input int es, input int em, input int er);
    vec_t v;
    v.s = s; v.i = i; v.c = c; v.es = es; v.em = em; v.er = er;
    return v;
  endfunction

  task automatic drive(input logic s, input logic i, input logic c);
    key_start_n = ~s;
    key_inc_n   = ~i;
    key_clr_n   = ~c;
  endtask

  task automatic press(input logic s, input logic i, input logic c);
    drive(s, i, c);
    repeat (10) @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clock);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic push_ticks(input int first_cyc, input int count, input int step);
    tick_t e;
    for (int k = 0; k < count; k++) begin
      model_mem = (model_mem + step) % MOD;
      e.cyc = first_cyc + k * TDIV;
      e.mem = model_mem;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  // Scoreboard: each tick_led pulse must match the next queued tick in cycle and memory.
  always @(negedge clock) begin
    if (!reset) begin
      if (tick_led) begin
        check("tick_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("tick_cycle", cyc, mon_e.cyc);
          check("tick_memory", int'(memory), mon_e.mem);
        end
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].cyc) begin
        mon_e = sb_q.pop_front();
        check("tick_missing", int'(tick_led), 1);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int c0;
    int k;

    // Vector table: from step 4 in SET, wrap through 31 -> 1, clr in SET, climb to 7.
    k = 0;
    for (int n = 0; n < 27; n++) begin
      vecs[k] = mk(1'b0, 1'b1, 1'b0, 5 + n, 0, 0);
      k++;
    end
    vecs[k] = mk(1'b0, 1'b1, 1'b0, 1, 0, 0); k++;
    vecs[k] = mk(1'b0, 1'b0, 1'b1, 1, 0, 0); k++;
    for (int n = 0; n < 6; n++) begin
      vecs[k] = mk(1'b0, 1'b1, 1'b0, 2 + n, 0, 0);
      k++;
    end
    vecs[k] = mk(1'b0, 1'b1, 1'b1, 7, 0, 0);

    // Reset values.
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check("reset_settings", int'(counter_settings), 1);
    check("reset_memory", int'(memory), 0);
    check("reset_run_led", int'(run_led), 0);
    check("reset_tick_led", int'(tick_led), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Three timed inc presses: each lands exactly DEB+3 clocks after the raw edge.
    for (int p = 1; p <= 3; p++) begin
      c0 = cyc;
      drive(1'b0, 1'b1, 1'b0);
      wait_cyc(c0 + DEB + 2);
      check("inc_latency_early", int'(counter_settings), p);
      wait_cyc(c0 + DEB + 3);
      check("inc_latency_land", int'(counter_settings), p + 1);
      wait_cyc(c0 + 10);
      drive(1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clock);
    end

    // Glitch one cycle shorter than the debounce window is ignored.
    drive(1'b0, 1'b1, 1'b0);
    repeat (DEB - 1) @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clock);
    check("glitch_ignored", int'(counter_settings), 4);

    // Table-driven presses in SET.
    for (int v = 0; v < NV; v++) begin
      press(vecs[v].s, vecs[v].i, vecs[v].c);
      check($sformatf("vec%0d_settings", v), int'(counter_settings), vecs[v].es);
      check($sformatf("vec%0d_memory", v), int'(memory), vecs[v].em);
      check($sformatf("vec%0d_run_led", v), int'(run_led), vecs[v].er);
    end

    // Step 7 run: 15 ticks, first one 5 cycles after RUN entry; inc ignored in RUN.
    c0 = cyc;
    model_mem = 0;
    drive(1'b1, 1'b0, 1'b0);
    push_ticks(c0 + DEB + 3 + TDIV, 15, 7);
    wait_cyc(c0 + DEB + 2);
    check("run_before_entry", int'(run_led), 0);
    wait_cyc(c0 + DEB + 3);
    check("run_entry", int'(run_led), 1);
    wait_cyc(c0 + 10);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(c0 + 20);
    drive(1'b0, 1'b1, 1'b0);
    wait_cyc(c0 + 30);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(c0 + 45);
    check("inc_ignored_run", int'(counter_settings), 7);

    // Start pulse coinciding with the 16th tick: PAUSE, tick discarded.
    wait_cyc(c0 + 80);
    drive(1'b1, 1'b0, 1'b0);
    wait_cyc(c0 + 86);
    check("still_run", int'(run_led), 1);
    wait_cyc(c0 + 87);
    check("pause_run_led", int'(run_led), 0);
    check("pause_memory", int'(memory), 5);
    check("pause_tick_led", int'(tick_led), 0);
    check("pause_sb_empty", sb_q.size(), 0);
    wait_cyc(c0 + 90);
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clock);

    // inc ignored in PAUSE, no ticks while paused.
    press(1'b0, 1'b1, 1'b0);
    check("inc_ignored_pause", int'(counter_settings), 7);
    check("pause_memory_hold", int'(memory), 5);
    check("pause_run_led_hold", int'(run_led), 0);

    // Resume: next tick a full period after re-entry; then clr.
    c0 = cyc;
    drive(1'b1, 1'b0, 1'b0);
    push_ticks(c0 + DEB + 3 + TDIV, 3, 7);
    wait_cyc(c0 + DEB + 3);
    check("resume_run_led", int'(run_led), 1);
    wait_cyc(c0 + 10);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(c0 + 18);
    drive(1'b0, 1'b0, 1'b1);
    wait_cyc(c0 + 25);
    check("clr_run_led", int'(run_led), 0);
    check("clr_memory", int'(memory), 0);
    check("clr_settings", int'(counter_settings), 7);
    check("clr_sb_empty", sb_q.size(), 0);
    wait_cyc(c0 + 28);
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clock);

    // Step 9, run to memory 42, then clr+start together.
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("step9", int'(counter_settings), 9);
    c0 = cyc;
    model_mem = 0;
    drive(1'b1, 1'b0, 1'b0);
    push_ticks(c0 + DEB + 3 + TDIV, 38, 9);
    wait_cyc(c0 + 10);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(c0 + 192);
    drive(1'b1, 1'b0, 1'b1);
    wait_cyc(c0 + 198);
    check("pre_clr_memory", int'(memory), 42);
    check("pre_clr_run_led", int'(run_led), 1);
    check("pre_clr_sb_empty", sb_q.size(), 0);
    wait_cyc(c0 + 199);
    check("clrstart_run_led", int'(run_led), 0);
    check("clrstart_memory", int'(memory), 0);
    check("clrstart_settings", int'(counter_settings), 9);
    check("clrstart_tick_led", int'(tick_led), 0);
    wait_cyc(c0 + 202);
    drive(1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clock);

    // Run step 9 to memory 37, then asynchronous reset with inc held through it.
    c0 = cyc;
    model_mem = 0;
    drive(1'b1, 1'b0, 1'b0);
    push_ticks(c0 + DEB + 3 + TDIV, 93, 9);
    wait_cyc(c0 + 10);
    drive(1'b0, 1'b0, 1'b0);
    wait_drain(600);
    wait_cyc(c0 + DEB + 3 + TDIV + 92 * TDIV);
    check("pre_reset_memory", int'(memory), 37);
    check("pre_reset_run_led", int'(run_led), 1);
    drive(1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_settings", int'(counter_settings), 1);
    check("async_reset_memory", int'(memory), 0);
    check("async_reset_run_led", int'(run_led), 0);
    check("async_reset_tick_led", int'(tick_led), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    c0 = cyc;
    wait_cyc(c0 + DEB + 2);
    check("held_key_early", int'(counter_settings), 1);
    check("held_key_run_led", int'(run_led), 0);
    wait_cyc(c0 + DEB + 3);
    check("held_key_accepted", int'(counter_settings), 2);
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clock);
    check("final_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
